// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan
//  Brief    : Time-multiplexed driver for a 4-digit common-anode seven-segment
//             display. Captures a packed BCD word once per scan frame, scans
//             one digit per REFRESH_DIV-cycle slot and optionally blanks
//             leading zeros. All display outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd,
    input  logic        blank_lz,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    localparam int               CNT_W       = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0]       c_last_idx  = 2'd3;
    localparam logic [3:0]       c_an_off    = 4'b1111;
    localparam logic [6:0]       c_seg_off   = 7'b1111111;
    localparam logic [6:0]       c_seg_dash  = 7'b0111111;

    // Prescaler, scan index (the only scan state) and frame shadow register
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      shd_q, shd_d;

    // Registered pin drivers
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;

    logic             tick;
    logic [3:0]       digit;
    logic             blank;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit
    function automatic logic [6:0] seg_code(input logic [3:0] val);
        logic [6:0] code;
        case (val)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = c_seg_dash;
        endcase
        return code;
    endfunction

    // Prescaler wrap, digit advance and once-per-frame BCD capture
    always_comb begin
        tick  = (cnt_q == c_cnt_max);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;
        // Loading on the edge where idx wraps to 0 keeps a frame tear-free
        shd_d = (tick && (idx_q == c_last_idx)) ? bcd : shd_q;
    end

    // Digit selection, leading-zero blanking and next pin values
    always_comb begin
        case (idx_q)
            2'd0:    digit = shd_q[3:0];
            2'd1:    digit = shd_q[7:4];
            2'd2:    digit = shd_q[11:8];
            default: digit = shd_q[15:12];
        endcase

        // A digit is a leading zero only if it and every higher digit are zero
        case (idx_q)
            2'd3:    blank = (shd_q[15:12] == 4'd0);
            2'd2:    blank = (shd_q[15:8]  == 8'd0);
            2'd1:    blank = (shd_q[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
        blank = blank && blank_lz;

        if (blank) begin
            an_d   = c_an_off;
            seg_d  = c_seg_off;
            dp_n_d = 1'b1;
        end else begin
            an_d   = ~(4'b0001 << idx_q);
            seg_d  = seg_code(digit);
            dp_n_d = ~dp[idx_q];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            shd_q  <= 16'h0000;
            an_q   <= c_an_off;
            seg_q  <= c_seg_off;
            dp_n_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            shd_q  <= shd_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp_n = dp_n_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scan
//  Brief    : Directed self-checking bench for seven_seg_scan, REFRESH_DIV=4.
//             Edge E0 is the last rising edge with reset high; a frame
//             boundary falls every 16 edges after it, and the first output of
//             each slot appears one edge after the slot starts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam int REFRESH_DIV = 4;
    localparam int FRAME       = 4 * REFRESH_DIV;

    localparam logic [6:0] c_s0    = 7'b1000000;
    localparam logic [6:0] c_s1    = 7'b1111001;
    localparam logic [6:0] c_s2    = 7'b0100100;
    localparam logic [6:0] c_s3    = 7'b0110000;
    localparam logic [6:0] c_s4    = 7'b0011001;
    localparam logic [6:0] c_s9    = 7'b0010000;
    localparam logic [6:0] c_sdash = 7'b0111111;
    localparam logic [6:0] c_soff  = 7'b1111111;

    logic        clk;
    logic        reset;
    logic [15:0] bcd;
    logic        blank_lz;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    int n_checks;
    int n_errors;

    seven_seg_scan #(.REFRESH_DIV(REFRESH_DIV)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bcd      (bcd),
        .blank_lz (blank_lz),
        .dp       (dp),
        .an       (an),
        .seg      (seg),
        .dp_n     (dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Check the pins for a whole 4-cycle output slot
    task automatic check_slot(input string tag, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_dpn);
        for (int k = 0; k < REFRESH_DIV; k++) begin
            edges(1);
            check({tag, " an"},   {12'd0, an},   {12'd0, e_an});
            check({tag, " seg"},  {9'd0, seg},   {9'd0, e_seg});
            check({tag, " dp_n"}, {15'd0, dp_n}, {15'd0, e_dpn});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bcd      = 16'h1234;
        blank_lz = 1'b0;
        dp       = 4'b0000;

        // Reset state
        edges(1);
        check("rst an",   {12'd0, an},   16'h000F);
        check("rst seg",  {9'd0, seg},   {9'd0, c_soff});
        check("rst dp_n", {15'd0, dp_n}, 16'h0001);
        edges(1);                       // E0
        reset = 1'b0;

        // E1: digit 0 from the cleared shadow register
        edges(1);
        check("e1 an",  {12'd0, an}, 16'h000E);
        check("e1 seg", {9'd0, seg}, {9'd0, c_s0});

        // Basic scan: first capture at E16
        edges(FRAME - 1);
        check_slot("scan d0", 4'b1110, c_s4, 1'b1);
        check_slot("scan d1", 4'b1101, c_s3, 1'b1);
        check_slot("scan d2", 4'b1011, c_s2, 1'b1);
        check_slot("scan d3", 4'b0111, c_s1, 1'b1);

        // Leading-zero blanking on 0042
        bcd      = 16'h0042;
        blank_lz = 1'b1;
        edges(FRAME);
        check_slot("lz42 d0", 4'b1110, c_s2,   1'b1);
        check_slot("lz42 d1", 4'b1101, c_s4,   1'b1);
        check_slot("lz42 d2", 4'b1111, c_soff, 1'b1);
        check_slot("lz42 d3", 4'b1111, c_soff, 1'b1);

        // All zeros: only digit 0 lit
        bcd = 16'h0000;
        edges(FRAME);
        check_slot("lz0 d0", 4'b1110, c_s0,   1'b1);
        check_slot("lz0 d1", 4'b1111, c_soff, 1'b1);
        check_slot("lz0 d2", 4'b1111, c_soff, 1'b1);
        check_slot("lz0 d3", 4'b1111, c_soff, 1'b1);

        // Invalid code shows a dash; decimal point on digit 1
        bcd = 16'h00A0;
        dp  = 4'b0010;
        edges(FRAME);
        check_slot("inv d0", 4'b1110, c_s0,    1'b1);
        check_slot("inv d1", 4'b1101, c_sdash, 1'b0);
        check_slot("inv d2", 4'b1111, c_soff,  1'b1);
        check_slot("inv d3", 4'b1111, c_soff,  1'b1);

        // Tear-free capture: change bcd while idx=1
        bcd      = 16'h1111;
        dp       = 4'b0000;
        blank_lz = 1'b0;
        edges(FRAME);
        check_slot("tear d0", 4'b1110, c_s1, 1'b1);
        bcd = 16'h2222;
        check_slot("tear d1", 4'b1101, c_s1, 1'b1);
        check_slot("tear d2", 4'b1011, c_s1, 1'b1);
        check_slot("tear d3", 4'b0111, c_s1, 1'b1);
        check_slot("new d0",  4'b1110, c_s2, 1'b1);
        check_slot("new d1",  4'b1101, c_s2, 1'b1);
        check_slot("new d2",  4'b1011, c_s2, 1'b1);
        check_slot("new d3",  4'b0111, c_s2, 1'b1);

        // Reset mid-frame with shd=9999 while idx=2
        bcd = 16'h9999;
        edges(FRAME);
        check_slot("pre d0", 4'b1110, c_s9, 1'b1);
        check_slot("pre d1", 4'b1101, c_s9, 1'b1);
        reset = 1'b1;
        edges(1);
        check("mid rst an",   {12'd0, an},   16'h000F);
        check("mid rst seg",  {9'd0, seg},   {9'd0, c_soff});
        check("mid rst dp_n", {15'd0, dp_n}, 16'h0001);
        reset = 1'b0;
        check_slot("post d0", 4'b1110, c_s0, 1'b1);
        edges(1);
        check("post d1 an",  {12'd0, an}, 16'h000D);
        check("post d1 seg", {9'd0, seg}, {9'd0, c_s0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It consumes the 16-bit packed BCD score produced by the binary-to-BCD stage and scans one digit at a time at a programmable refresh rate. It captures the BCD word once per scan frame so a digit never tears mid-frame, and it optionally blanks leading zeros. All outputs are registered and drive the display pins directly.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (100 MHz gives 1 kHz per digit). Legal range is ≥ 2.
- clk  in  1  system clock; every flop is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bcd  in  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- blank_lz  in  1  1 = blank leading zeros; sampled every cycle.
- dp  in  4  decimal-point request per digit (bit i = digit i); sampled every cycle.
- an  out  4  digit anodes, active-low, one-hot-low or all-high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.

## Operation
- **Prescaler `cnt`**
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - `tick` = (cnt == REFRESH_DIV-1), combinational.
- **Digit index `idx`** (2 bits)
  - Advances on `tick`, sequence 0→1→2→3→0.
  - No other state machine exists; `idx` is the scan state.
- **Shadow register `shd`** (16 bits)
  - Loads `bcd` on a cycle with `tick` && idx==3, i.e. the edge on which idx wraps to 0.
  - It is the only path from `bcd` to the display.
  - Changes on `bcd` between frame boundaries are invisible until the next boundary.
- **Digit select:** d = shd[4*idx+3 : 4*idx].
- **Blanking**, applied only when blank_lz=1:
  - digit 3 is blank if d3==0;
  - digit 2 is blank if d3==d2==0;
  - digit 1 is blank if d3==d2==d1==0;
  - digit 0 is never blanked.
  - A blank digit drives an=4'b1111, seg=7'b1111111 and dp_n=1 for its whole slot.
- **Anodes:** for a non-blank digit, an = ~(4'b0001 << idx).
- **Segment codes:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 are invalid and display a dash, 0111111.
- **Decimal point:** dp_n = ~dp[idx] for a non-blank digit.
- **Reset values:** cnt=0, idx=0, shd=16'h0000, an=4'b1111, seg=7'b1111111, dp_n=1.
- **Reset mid-frame:** all state returns to reset values on the next edge. Scanning restarts at digit 0 with a full REFRESH_DIV-cycle slot.

## Timing
- an, seg and dp_n are registered from the current idx, shd, blank_lz and dp.
- Output latency is 1 cycle: outputs reflect the idx/shd value held in the previous cycle.
- After reset deasserts at edge E0:
  - Edge E1 shows digit 0 from shd=0. The display shows "0", with an=4'b1110 and seg=1000000, unless dp changes it.
  - The first tick is high during the cycle where cnt == REFRESH_DIV-1.
  - idx becomes 1 at edge E(REFRESH_DIV), and the outputs switch one edge later.
- Each digit slot lasts exactly REFRESH_DIV cycles. One frame lasts 4·REFRESH_DIV cycles.
- The first capture of `bcd` happens at the edge ending slot 3, edge E(4·REFRESH_DIV). The new value appears on outputs one cycle later.
- Capture and display of digit 0 coincide at a frame boundary. The digit-0 output uses the newly loaded shd, so it appears at the first output of the slot.
- Changing blank_lz or dp takes effect on the next output update (1 cycle); it is not frame-synchronised.

## Test plan
All scenarios use REFRESH_DIV=4.

- **Basic scan:** reset, then bcd=16'h1234, blank_lz=0, dp=0. After the first frame boundary the outputs cycle, with each pair held 4 cycles:
  - an=1110 / seg=0011001
  - an=1101 / seg=0110000
  - an=1011 / seg=0100100
  - an=0111 / seg=1111001
- **Leading-zero blanking:** bcd=16'h0042, blank_lz=1.
  - Slot 0: seg=0100100.
  - Slot 1: seg=0011001.
  - Slots 2 and 3: an=1111, seg=1111111.
  - Repeating with bcd=16'h0000 leaves only digit 0 lit, showing 1000000.
- **Invalid digit and dp:** bcd=16'h00A0, dp=4'b0010, blank_lz=1.
  - Slot 1: an=1101, seg=0111111, dp_n=0.
  - Slot 0: seg=1000000, dp_n=1.
- **Tear-free capture:** bcd=16'h1111. Switch to 16'h2222 while idx=1.
  - Slots 1–3 of the current frame still show 1111001.
  - All slots of the next frame show 0100100.
- **Reset mid-frame:** assert reset for 1 cycle while idx=2 and shd=16'h9999.
  - At the next edge: an=1111, seg=1111111, dp_n=1.
  - Afterwards digit 0 shows 1000000 for 4 cycles, then the next slot begins.
